// File: rtl/loader_pkg.sv
// Shared types and default widths for the UART program loader.
package loader_pkg;

    localparam int                 DEF_MEMORY_WIDTH     = 8;
    localparam int                 DEF_MEMORY_DEPTH     = 256;
    localparam int                 DEF_NB_ADDR          = 32;
    localparam int                 DEF_NB_INSTRUCTION   = 32;
    localparam logic [31:0]        DEF_HALT_INSTRUCTION = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BYTE,
        ST_WRITE,
        ST_CHECKSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Shifts written bytes into an instruction word (first byte MSB) and flags the
// halt word as soon as its last byte is presented.
module loader_word_assembler
    import loader_pkg::*;
#(
    parameter int                         MEMORY_WIDTH     = DEF_MEMORY_WIDTH,
    parameter int                         NB_INSTRUCTION   = DEF_NB_INSTRUCTION,
    parameter logic [NB_INSTRUCTION-1:0]  HALT_INSTRUCTION = NB_INSTRUCTION'(DEF_HALT_INSTRUCTION)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_shift,
    input  logic [MEMORY_WIDTH-1:0] i_byte,
    output logic                    o_halt_match
);

    localparam int HIST_W = NB_INSTRUCTION - MEMORY_WIDTH;

    // Only the earlier bytes of the word are stored; the newest comes straight from i_byte.
    logic [HIST_W-1:0]         hist_q, hist_d;
    logic [NB_INSTRUCTION-1:0] word_next;

    assign word_next    = {hist_q, i_byte};
    assign o_halt_match = (word_next == HALT_INSTRUCTION);

    always_comb begin
        hist_d = hist_q;
        if (i_clear)
            hist_d = '0;
        else if (i_shift)
            hist_d = word_next[HIST_W-1:0];
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) hist_q <= '0;
        else          hist_q <= hist_d;
    end

endmodule

// File: rtl/program_loader.sv
// Loads a program byte stream from a UART receiver into instruction memory until
// the halt word. Define PROGRAM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int                         MEMORY_WIDTH     = DEF_MEMORY_WIDTH,
    parameter int                         MEMORY_DEPTH     = DEF_MEMORY_DEPTH,
    parameter int                         NB_ADDR          = DEF_NB_ADDR,
    parameter int                         NB_INSTRUCTION   = DEF_NB_INSTRUCTION,
    parameter logic [NB_INSTRUCTION-1:0]  HALT_INSTRUCTION = NB_INSTRUCTION'(DEF_HALT_INSTRUCTION)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [MEMORY_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_done,
    output logic                    o_write_enable,
    output logic [MEMORY_WIDTH-1:0] o_write_data,
    output logic [NB_ADDR-1:0]      o_addr,
    output logic                    o_loading,
    output logic                    o_done,
    output logic                    o_error,
    output logic                    o_checksum_error
);

    localparam int               WB        = $clog2(NB_INSTRUCTION / MEMORY_WIDTH);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);

    loader_state_t             state_q, state_d;
    logic [NB_ADDR-1:0]        addr_q, addr_d;
    logic [MEMORY_WIDTH-1:0]   byte_q, byte_d;
    logic                      we_q, we_d;
    logic                      loading_q, loading_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic                      word_clr, word_shift, halt_match, word_end;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [MEMORY_WIDTH-1:0]   csum_q, csum_d;
    logic                      cerr_q, cerr_d;
`endif

    assign word_end = &addr_q[WB-1:0];

    loader_word_assembler #(
        .MEMORY_WIDTH     (MEMORY_WIDTH),
        .NB_INSTRUCTION   (NB_INSTRUCTION),
        .HALT_INSTRUCTION (HALT_INSTRUCTION)
    ) u_word (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (word_clr),
        .i_shift      (word_shift),
        .i_byte       (byte_q),
        .o_halt_match (halt_match)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_d     = byte_q;
        we_d       = 1'b0;
        done_d     = done_q;
        error_d    = error_q;
        word_clr   = 1'b0;
        word_shift = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        cerr_d     = cerr_q;
`endif
        // Start has priority over any byte arriving in the same cycle.
        if (i_start) begin
            state_d  = ST_WAIT_BYTE;
            addr_d   = '0;
            done_d   = 1'b0;
            error_d  = 1'b0;
            word_clr = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d   = '0;
            cerr_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_WAIT_BYTE: begin
                    if (i_rx_done) begin
                        byte_d  = i_rx_data;
                        we_d    = 1'b1;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (i_rx_done) error_d = 1'b1;
                    word_shift = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_q;
`endif
                    if (word_end && halt_match) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECKSUM;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_BYTE;
                        addr_d  = addr_q + NB_ADDR'(1);
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHECKSUM: begin
                    if (i_rx_done) begin
                        cerr_d  = (i_rx_data != csum_q);
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
        loading_d = (state_d == ST_WAIT_BYTE) || (state_d == ST_WRITE) ||
                    (state_d == ST_CHECKSUM);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            byte_q    <= '0;
            we_q      <= 1'b0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
            cerr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            byte_q    <= byte_d;
            we_q      <= we_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
            cerr_q    <= cerr_d;
`endif
        end
    end

    assign o_write_enable = we_q;
    assign o_write_data   = byte_q;
    assign o_addr         = addr_q;
    assign o_loading      = loading_q;
    assign o_done         = done_q;
    assign o_error        = error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign o_checksum_error = cerr_q;
`else
    assign o_checksum_error = 1'b0;
`endif

endmodule
